// File: rtl/bsg_fsb_pkg.sv
// ============================================================================
// Module      : bsg_fsb_pkg
// Description : Shared types and sizing helpers for the FSB-to-link serializer.
//               BSG_FSB_SERIALIZER_PARITY_EN adds one parity bit to each flit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bsg_fsb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

`ifdef BSG_FSB_SERIALIZER_PARITY_EN
  localparam int unsigned parity_width_lp = 1;
`else
  localparam int unsigned parity_width_lp = 0;
`endif

  function automatic int unsigned num_flits(input int unsigned ring_w,
                                            input int unsigned flit_w);
    return (ring_w + flit_w - 1) / flit_w;
  endfunction

  // A single-flit packet still needs a one-bit index so the counter has a port.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_fsb_to_link_serializer_if.sv
// ============================================================================
// Module      : bsg_fsb_to_link_serializer_if
// Description : FSB packet input and link flit output handshakes.
//               data_o widens by one bit under BSG_FSB_SERIALIZER_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bsg_fsb_to_link_serializer_if #(
  parameter int unsigned ring_width_p = 80,
  parameter int unsigned flit_width_p = 16
);

  localparam int unsigned data_o_width_lp = flit_width_p + bsg_fsb_pkg::parity_width_lp;

  logic                       v_i;
  logic [ring_width_p-1:0]    data_i;
  logic                       yumi_o;
  logic                       v_o;
  logic [data_o_width_lp-1:0] data_o;
  logic                       ready_i;

  modport slave (
    input  v_i,
    input  data_i,
    input  ready_i,
    output yumi_o,
    output v_o,
    output data_o
  );

  modport master (
    output v_i,
    output data_i,
    output ready_i,
    input  yumi_o,
    input  v_o,
    input  data_o
  );

endinterface

`default_nettype wire

// File: rtl/bsg_counter_clear_up.sv
// ============================================================================
// Module      : bsg_counter_clear_up
// Description : Up counter with synchronous clear; clear has priority over up.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_counter_clear_up #(
  parameter int unsigned width_p = 3
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_q;
  logic [width_p-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (up_i) begin
      count_d = count_q + width_p'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/bsg_fsb_to_link_serializer.sv
// ============================================================================
// Module      : bsg_fsb_to_link_serializer
// Description : Splits one FSB packet into LSB-first flits for a link.
//               BSG_FSB_SERIALIZER_PARITY_EN appends even parity as flit MSB.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_fsb_to_link_serializer
  import bsg_fsb_pkg::*;
#(
  parameter int unsigned ring_width_p = 80,
  parameter int unsigned flit_width_p = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  bsg_fsb_to_link_serializer_if.slave   link
);

  localparam int unsigned num_flits_lp    = num_flits(ring_width_p, flit_width_p);
  localparam int unsigned idx_width_lp    = idx_width(num_flits_lp);
  localparam int unsigned padded_width_lp = num_flits_lp * flit_width_p;
  localparam logic [idx_width_lp-1:0] last_idx_lp = idx_width_lp'(num_flits_lp - 1);

  state_e                                     state_q;
  state_e                                     state_d;
  logic [num_flits_lp-1:0][flit_width_p-1:0]  data_q;
  logic [num_flits_lp-1:0][flit_width_p-1:0]  data_d;
  logic [padded_width_lp-1:0]                 data_ext;
  logic [idx_width_lp-1:0]                    idx;
  logic [flit_width_p-1:0]                    flit_payload;
  logic                                       flit_xfer;
  logic                                       last_flit;
  logic                                       capture;

  always_comb begin
    data_ext                    = '0;
    data_ext[ring_width_p-1:0]  = link.data_i;
  end

  assign flit_xfer = (state_q == SEND) & link.ready_i;
  assign last_flit = (idx == last_idx_lp);

  // A new packet may be taken in the same cycle the last flit leaves, so
  // back-to-back packets stream without a bubble.
  always_comb begin
    capture = 1'b0;
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      IDLE: capture = link.v_i;
      SEND: begin
        if (flit_xfer && last_flit) begin
          capture = link.v_i;
          if (!link.v_i) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    capture = capture & reset_n_i;
    if (capture) begin
      state_d = SEND;
      data_d  = data_ext;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  bsg_counter_clear_up #(
    .width_p (idx_width_lp)
  ) u_idx_counter (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (capture),
    .up_i      (flit_xfer & ~last_flit),
    .count_o   (idx)
  );

  assign flit_payload = data_q[idx];
  assign link.yumi_o  = capture;
  assign link.v_o     = (state_q == SEND);

`ifdef BSG_FSB_SERIALIZER_PARITY_EN
  assign link.data_o = {^flit_payload, flit_payload};
`else
  assign link.data_o = flit_payload;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bsg_fsb_to_link_serializer.sv
// ============================================================================
// Module      : tb_bsg_fsb_to_link_serializer
// Description : Directed vector bench for the FSB-to-link serializer.
//               Expected flits carry parity when BSG_FSB_SERIALIZER_PARITY_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bsg_fsb_to_link_serializer;

  typedef struct {
    logic        v;
    logic [79:0] d;
    logic        r;
    logic        ey;
    logic        ev;
    logic [15:0] ed;
  } vec_t;

  localparam logic [79:0] P1 = 80'h0123_4567_89AB_CDEF_1122;
  localparam logic [79:0] P2 = 80'hFEDC_BA98_7654_3210_AABB;
  localparam logic [79:0] P3 = 80'h0000_0000_0000_0003_0001;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  vec_t tbl[$];

  bsg_fsb_to_link_serializer_if #(.ring_width_p(80), .flit_width_p(16)) lk ();
  bsg_fsb_to_link_serializer_if #(.ring_width_p(72), .flit_width_p(16)) lk72 ();

  bsg_fsb_to_link_serializer #(.ring_width_p(80), .flit_width_p(16)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .link      (lk.slave)
  );

  bsg_fsb_to_link_serializer #(.ring_width_p(72), .flit_width_p(16)) dut72 (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .link      (lk72.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] fl(input logic [15:0] p);
`ifdef BSG_FSB_SERIALIZER_PARITY_EN
    return {15'b0, ^p, p};
`else
    return {16'b0, p};
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [79:0] d, input logic r,
                     input logic ey, input logic ev, input logic [15:0] ed);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.ey = ey; t.ev = ev; t.ed = ed;
    tbl.push_back(t);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // back-to-back packets, full rate
    add(1, P1, 1, 1, 0, 16'h0);
    add(0, 0,  1, 0, 1, 16'h1122);
    add(0, 0,  1, 0, 1, 16'hCDEF);
    add(0, 0,  1, 0, 1, 16'h89AB);
    add(0, 0,  1, 0, 1, 16'h4567);
    add(1, P2, 1, 1, 1, 16'h0123);
    add(0, 0,  1, 0, 1, 16'hAABB);
    add(0, 0,  1, 0, 1, 16'h3210);
    add(0, 0,  1, 0, 1, 16'h7654);
    add(0, 0,  1, 0, 1, 16'hBA98);
    add(0, 0,  1, 0, 1, 16'hFEDC);
    add(0, 0,  1, 0, 0, 16'h0);
    // ready stalls, with a pending packet offered
    add(1, P1, 1, 1, 0, 16'h0);
    add(0, 0,  1, 0, 1, 16'h1122);
    add(1, P2, 0, 0, 1, 16'hCDEF);
    add(1, P2, 0, 0, 1, 16'hCDEF);
    add(0, 0,  1, 0, 1, 16'hCDEF);
    add(1, P2, 0, 0, 1, 16'h89AB);
    add(0, 0,  1, 0, 1, 16'h89AB);
    add(0, 0,  1, 0, 1, 16'h4567);
    add(1, P2, 0, 0, 1, 16'h0123);
    add(0, 0,  1, 0, 1, 16'h0123);
    add(0, 0,  0, 0, 0, 16'h0);
    // small payloads exercising parity
    add(1, P3, 0, 1, 0, 16'h0);
    add(0, 0,  1, 0, 1, 16'h0001);
    add(0, 0,  1, 0, 1, 16'h0003);
    add(0, 0,  1, 0, 1, 16'h0000);
    add(0, 0,  1, 0, 1, 16'h0000);
    add(0, 0,  1, 0, 1, 16'h0000);
    add(0, 0,  1, 0, 0, 16'h0);

    rst_n       = 1'b0;
    lk.v_i      = 1'b1;
    lk.data_i   = P1;
    lk.ready_i  = 1'b1;
    lk72.v_i    = 1'b0;
    lk72.data_i = '0;
    lk72.ready_i = 1'b1;
    #3;
    chk("reset v_o", 32'(lk.v_o), 32'd0);
    chk("reset yumi", 32'(lk.yumi_o), 32'd0);
    next_cycle();
    next_cycle();
    rst_n  = 1'b1;
    lk.v_i = 1'b0;
    next_cycle();

    for (int i = 0; i < tbl.size(); i++) begin
      lk.v_i     = tbl[i].v;
      lk.data_i  = tbl[i].d;
      lk.ready_i = tbl[i].r;
      @(negedge clk);
      chk($sformatf("vec%0d yumi", i), 32'(lk.yumi_o), 32'(tbl[i].ey));
      chk($sformatf("vec%0d v_o", i), 32'(lk.v_o), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d data", i), 32'(lk.data_o), fl(tbl[i].ed));
      end
      next_cycle();
    end

    // reset mid-packet after two flit handshakes
    lk.v_i     = 1'b1;
    lk.data_i  = P1;
    lk.ready_i = 1'b1;
    next_cycle();
    lk.v_i = 1'b0;
    next_cycle();
    next_cycle();
    chk("pre-reset v_o", 32'(lk.v_o), 32'd1);
    chk("pre-reset data", 32'(lk.data_o), fl(16'h89AB));
    #2;
    rst_n  = 1'b0;
    lk.v_i = 1'b1;
    #1;
    chk("mid-reset v_o", 32'(lk.v_o), 32'd0);
    chk("mid-reset yumi", 32'(lk.yumi_o), 32'd0);
    next_cycle();
    rst_n  = 1'b1;
    lk.v_i = 1'b0;
    @(negedge clk);
    chk("post-reset v_o", 32'(lk.v_o), 32'd0);
    next_cycle();
    lk.v_i    = 1'b1;
    lk.data_i = P2;
    @(negedge clk);
    chk("post-reset yumi", 32'(lk.yumi_o), 32'd1);
    next_cycle();
    lk.v_i = 1'b0;
    @(negedge clk);
    chk("post-reset flit0", 32'(lk.data_o), fl(16'hAABB));
    next_cycle();
    @(negedge clk);
    chk("post-reset flit1", 32'(lk.data_o), fl(16'h3210));
    for (int i = 0; i < 4; i++) next_cycle();
    @(negedge clk);
    chk("post-reset drained", 32'(lk.v_o), 32'd0);
    next_cycle();

    // 72-bit packet: top flit is zero-padded
    lk72.v_i    = 1'b1;
    lk72.data_i = '1;
    @(negedge clk);
    chk("r72 yumi", 32'(lk72.yumi_o), 32'd1);
    next_cycle();
    lk72.v_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("r72 v_o%0d", i), 32'(lk72.v_o), 32'd1);
      chk($sformatf("r72 flit%0d", i), 32'(lk72.data_o),
          fl((i < 4) ? 16'hFFFF : 16'h00FF));
      next_cycle();
    end
    @(negedge clk);
    chk("r72 idle", 32'(lk72.v_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bsg_fsb_to_link_serializer.md
BSG_FSB_TO_LINK_SERIALIZER -- requirements
Module: bsg_fsb_to_link_serializer

Interface
REQ-001 Parameter ring_width_p, default 80: width of one FSB packet accepted on data_i.
REQ-002 Parameter flit_width_p, default 16: payload width of one outgoing flit.
REQ-003 Derived constant num_flits_lp = ceil(ring_width_p/flit_width_p); flit index counter width = max(1, clog2(num_flits_lp)).
REQ-004 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n_i  input  1  asynchronous, active-low reset.
REQ-006 v_i  input  1  FSB packet valid.
REQ-007 data_i  input  ring_width_p  FSB packet; low-order bits hold useful data.
REQ-008 yumi_o  output  1  packet consumed this cycle; asserted only when v_i=1.
REQ-009 v_o  output  1  flit valid.
REQ-010 data_o  output  flit_width_p (+1 with parity, see Configuration)  outgoing flit.
REQ-011 ready_i  input  1  downstream can take a flit; transfer occurs when v_o & ready_i.

Function
REQ-012 Two states: IDLE (no packet held) and SEND (packet held, flits pending).
REQ-013 In IDLE, yumi_o = v_i; on yumi_o, data_i is captured zero-extended to num_flits_lp*flit_width_p bits, the flit index is cleared to 0 and the state moves to SEND.
REQ-014 In SEND, v_o = 1 and data_o = captured bits [idx*flit_width_p +: flit_width_p]; flit 0 is the least-significant slice.
REQ-015 v_o = 0 in IDLE; latency from the yumi_o cycle to the first v_o is exactly 1 cycle.
REQ-016 On v_o & ready_i with idx < num_flits_lp-1, idx increments by 1 and the state stays SEND.
REQ-017 On v_o & ready_i with idx = num_flits_lp-1 (last flit): if v_i=1, yumi_o=1 in the same cycle, the new packet is captured, idx returns to 0 and the state stays SEND (no bubble); otherwise the state returns to IDLE.
REQ-018 yumi_o = 0 in SEND except in the last-flit handshake cycle of REQ-017.
REQ-019 While ready_i=0 in SEND, data_o, v_o and idx hold steady and yumi_o=0.
REQ-020 With num_flits_lp=1, every accepted packet produces a single flit and back-to-back packets stream at one per cycle when ready_i stays 1.
REQ-021 Padding bits above ring_width_p in the last flit are 0.
REQ-022 Transmitted flits are never reordered, dropped or duplicated.

Reset
REQ-023 reset_n_i=0 immediately forces state IDLE, idx 0, held packet 0; v_o=0 and yumi_o=0 follow combinationally.
REQ-024 Reset asserted mid-packet discards remaining flits; after deassertion the next accepted packet starts at flit 0.
REQ-025 Reset deassertion is synchronous to clk_i at the integration level; no acceptance occurs in the deassertion cycle.

Configuration
REQ-026 Macro BSG_FSB_SERIALIZER_PARITY_EN defined: data_o is flit_width_p+1 bits, MSB = even parity (XOR) of the flit payload bits [flit_width_p-1:0].
REQ-027 Macro undefined: data_o is exactly flit_width_p bits, no parity logic present.

Structure
REQ-028 The state enum typedef (IDLE, SEND) and the num-flits ceiling function reside in bsg_fsb_pkg.
REQ-029 Flit index uses the existing bsg_counter_clear_up sub-module (clear on capture, up on non-last flit handshake); no other sub-module is instantiated.

Verification
REQ-030 ring 80, flit 16, data_i=0x0123_4567_89AB_CDEF_1122, ready_i=1 -> flits 0x1122,0xCDEF,0x89AB,0x4567,0x0123 on 5 consecutive cycles starting 1 cycle after yumi_o.
REQ-031 Two packets presented back-to-back, ready_i=1 -> 10 flits on 10 consecutive cycles; second yumi_o coincides with first packet's 5th flit handshake.
REQ-032 ready_i toggled 1,0,0,1,... during a packet -> data_o held stable during ready_i=0 cycles; all 5 flits delivered in order, yumi_o stays 0.
REQ-033 ring 72, flit 16, data_i all-ones -> last (5th) flit = 0x00FF.
REQ-034 reset_n_i pulsed low after flit 2 handshake -> v_o drops immediately; next packet begins with its flit 0.
REQ-035 PARITY_EN defined, flit payload 0x0001 -> data_o=0x1_0001; payload 0x0003 -> data_o=0x0_0003.
